// File: rtl/f1_pkg.sv
// Shared types and constants for the F1 reaction timer.
package f1_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        TIMING = 2'd2,
        DONE   = 2'd3
    } f1_state_t;

    localparam logic [7:0] LIGHTS_ALL_ON  = 8'hFF;
    localparam logic [7:0] LIGHTS_ALL_OFF = 8'h00;

endpackage

// File: rtl/f1_ms_tick.sv
// Millisecond prescaler: one-cycle tick every TICK_DIV enabled cycles, with synchronous clear.
module f1_ms_tick #(
    parameter int TICK_DIV = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] presc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc <= '0;
        end else if (clr) begin
            presc <= '0;
        end else if (en) begin
            presc <= (presc == LAST) ? '0 : presc + PW'(1);
        end
    end

    assign tick = en && !clr && (presc == LAST);

endmodule

// File: rtl/f1_reaction_timer.sv
// F1 reaction timer: arms on all lights on, times from lights-out to trigger press.
// Optional build macro F1_TRIGGER_SYNC_EN adds a two-flop trigger synchroniser.
module f1_reaction_timer
    import f1_pkg::*;
#(
    parameter int TICK_DIV   = 1000,
    parameter int CNT_WIDTH  = 16,
    parameter int TIMEOUT_MS = 9999
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           lights,
    input  logic                 trigger,
    input  logic                 result_ready,
    output logic [CNT_WIDTH-1:0] result_ms,
    output logic                 result_valid,
    output logic                 false_start,
    output logic                 timeout,
    output logic                 busy
);

    localparam logic [CNT_WIDTH-1:0] TMO = CNT_WIDTH'(TIMEOUT_MS);

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (v >= TMO) ? TMO : v + CNT_WIDTH'(1);
    endfunction

    f1_state_t state, state_nxt;

    logic                 trig_s;
    logic                 trig_p0, trig_p1;
    logic                 trig_edge;
    logic                 tick;
    logic [CNT_WIDTH-1:0] cnt, cnt_inc;
    logic                 load;
    logic [CNT_WIDTH-1:0] res_nxt;
    logic                 fs_nxt, to_nxt;

`ifdef F1_TRIGGER_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[0], trigger};
        end
    end

    assign trig_s = sync_q[1];
`else
    assign trig_s = trigger;
`endif

    // Edge detect stage: p0 is the registered trigger, p1 its history.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trig_p0 <= 1'b0;
            trig_p1 <= 1'b0;
        end else begin
            trig_p0 <= trig_s;
            trig_p1 <= trig_p0;
        end
    end

    assign trig_edge = trig_p0 & ~trig_p1;

    f1_ms_tick #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (state != TIMING),
        .en   (state == TIMING),
        .tick (tick)
    );

    // Value the counter takes this cycle, so a same-cycle tick is included in a result.
    assign cnt_inc = tick ? sat_inc(cnt) : cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        res_nxt   = '0;
        fs_nxt    = 1'b0;
        to_nxt    = 1'b0;
        case (state)
            IDLE: begin
                if (lights == LIGHTS_ALL_ON) begin
                    state_nxt = ARMED;
                end
            end
            ARMED: begin
                if (trig_edge) begin
                    state_nxt = DONE;
                    load      = 1'b1;
                    fs_nxt    = (lights != LIGHTS_ALL_OFF);
                end else if (lights == LIGHTS_ALL_OFF) begin
                    state_nxt = TIMING;
                end else if (lights != LIGHTS_ALL_ON) begin
                    state_nxt = IDLE;
                end
            end
            TIMING: begin
                // Timeout takes priority over a press in the same cycle.
                if (cnt_inc == TMO) begin
                    state_nxt = DONE;
                    load      = 1'b1;
                    res_nxt   = TMO;
                    to_nxt    = 1'b1;
                end else if (trig_edge) begin
                    state_nxt = DONE;
                    load      = 1'b1;
                    res_nxt   = cnt_inc;
                end
            end
            DONE: begin
                if (result_valid && result_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (state == TIMING) begin
            cnt <= cnt_inc;
        end else begin
            cnt <= '0;
        end
    end

    // Result stage: registered outputs, held while the consumer stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_ms    <= '0;
            result_valid <= 1'b0;
            false_start  <= 1'b0;
            timeout      <= 1'b0;
            busy         <= 1'b0;
        end else begin
            busy <= (state == ARMED) || (state == TIMING);
            if (load) begin
                result_ms    <= res_nxt;
                result_valid <= 1'b1;
                false_start  <= fs_nxt;
                timeout      <= to_nxt;
            end else if (state == DONE && result_valid && result_ready) begin
                result_valid <= 1'b0;
                false_start  <= 1'b0;
                timeout      <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_f1_reaction_timer.sv
// Self-checking bench for f1_reaction_timer: directed scenarios plus randomized transactions.
module tb_f1_reaction_timer;

    localparam int TD   = 4;
    localparam int CW   = 16;
    localparam int TOMS = 20;

    localparam int PH_IDLE = 0;
    localparam int PH_WAIT = 1;
    localparam int PH_RUN  = 2;
    localparam int PH_RES  = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    lights = 8'h00;
    logic          trigger = 1'b0;
    logic          result_ready = 1'b0;
    logic [CW-1:0] result_ms;
    logic          result_valid;
    logic          false_start;
    logic          timeout;
    logic          busy;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: phase of the measurement and cycles since lights-out.
    int ph = PH_IDLE;
    int elapsed = 0;
    bit t1 = 1'b0;
    bit t2 = 1'b0;
    int m_ms = 0, m_v = 0, m_fs = 0, m_to = 0, m_busy = 0;

    f1_reaction_timer #(
        .TICK_DIV   (TD),
        .CNT_WIDTH  (CW),
        .TIMEOUT_MS (TOMS)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .lights       (lights),
        .trigger      (trigger),
        .result_ready (result_ready),
        .result_ms    (result_ms),
        .result_valid (result_valid),
        .false_start  (false_start),
        .timeout      (timeout),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", n_checks, n_errors);
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        ph = PH_IDLE; elapsed = 0; t1 = 1'b0; t2 = 1'b0;
        m_ms = 0; m_v = 0; m_fs = 0; m_to = 0; m_busy = 0;
    endtask

    // One clock edge of the behavioural model, using the inputs presented to that edge.
    task automatic model_step();
        bit pressed;
        pressed = t1 && !t2;
        m_busy = (ph == PH_WAIT || ph == PH_RUN) ? 1 : 0;
        t2 = t1;
        t1 = trigger;
        case (ph)
            PH_IDLE: if (lights == 8'hFF) ph = PH_WAIT;
            PH_WAIT: begin
                if (pressed) begin
                    ph = PH_RES; m_v = 1; m_ms = 0; m_to = 0;
                    m_fs = (lights != 8'h00) ? 1 : 0;
                end else if (lights == 8'h00) begin
                    ph = PH_RUN; elapsed = 0;
                end else if (lights != 8'hFF) begin
                    ph = PH_IDLE;
                end
            end
            PH_RUN: begin
                elapsed++;
                if (elapsed / TD >= TOMS) begin
                    ph = PH_RES; m_v = 1; m_ms = TOMS; m_to = 1; m_fs = 0;
                end else if (pressed) begin
                    ph = PH_RES; m_v = 1; m_ms = elapsed / TD; m_to = 0; m_fs = 0;
                end
            end
            default: begin
                if (result_ready) begin
                    ph = PH_IDLE; m_v = 0; m_fs = 0; m_to = 0;
                end
            end
        endcase
    endtask

    task automatic compare_all();
        check_eq("result_ms", 32'(result_ms), 32'(m_ms));
        check_eq("result_valid", 32'(result_valid), 32'(m_v));
        check_eq("false_start", 32'(false_start), 32'(m_fs));
        check_eq("timeout", 32'(timeout), 32'(m_to));
        check_eq("busy", 32'(busy), 32'(m_busy));
    endtask

    task automatic cycle(input logic [7:0] l, input logic t, input logic r);
        @(negedge clk);
        lights = l; trigger = t; result_ready = r;
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    initial begin
        int first_v, busy_fall, seen;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_ms", 32'(result_ms), 0);
        check_eq("rst_valid", 32'(result_valid), 0);
        check_eq("rst_fs", 32'(false_start), 0);
        check_eq("rst_to", 32'(timeout), 0);
        check_eq("rst_busy", 32'(busy), 0);
        rst = 1'b0;

        // Normal measurement: press 30 cycles after lights-out gives 7 ms.
        repeat (2) cycle(8'h00, 1'b0, 1'b0);
        repeat (3) cycle(8'hFF, 1'b0, 1'b0);
        first_v = -1;
        for (int i = 0; i < 40; i++) begin
            cycle(8'h00, (i >= 30), 1'b0);
            if (result_valid && first_v < 0) first_v = i;
        end
        check_eq("t1_latency", 32'(first_v), 31);
        check_eq("t1_ms", 32'(result_ms), 7);
        check_eq("t1_flags", 32'({false_start, timeout}), 0);

        // Backpressure: everything held while ready stays low.
        for (int i = 0; i < 50; i++) begin
            cycle(8'($urandom), 1'($urandom_range(0, 1)), 1'b0);
            if (!result_valid || result_ms != 7) check_eq("hold_stable", 32'(result_ms), 7);
        end
        cycle(8'h00, 1'b0, 1'b1);
        cycle(8'h00, 1'b0, 1'b0);
        check_eq("hs_valid_low", 32'(result_valid), 0);
        check_eq("hs_ms_kept", 32'(result_ms), 7);

        // False start while lights are still on.
        repeat (2) cycle(8'hFF, 1'b0, 1'b0);
        first_v = -1; busy_fall = -1;
        for (int i = 0; i < 6; i++) begin
            cycle(8'hFF, 1'b1, 1'b0);
            if (result_valid && first_v < 0) first_v = i;
            if (first_v >= 0 && !busy && busy_fall < 0) busy_fall = i;
        end
        check_eq("fs_flag", 32'(false_start), 1);
        check_eq("fs_ms", 32'(result_ms), 0);
        check_eq("fs_busy_lag", 32'(busy_fall - first_v), 1);
        cycle(8'h00, 1'b0, 1'b1);
        cycle(8'h00, 1'b0, 1'b0);

        // Timeout with no press.
        repeat (2) cycle(8'hFF, 1'b0, 1'b0);
        first_v = -1;
        for (int i = 0; i < 90; i++) begin
            cycle(8'h00, 1'b0, 1'b0);
            if (result_valid && first_v < 0) first_v = i;
        end
        check_eq("to_latency", 32'(first_v), 80);
        check_eq("to_flag", 32'(timeout), 1);
        check_eq("to_ms", 32'(result_ms), TOMS);
        cycle(8'h00, 1'b0, 1'b1);

        // Abort from ARMED, then a press in IDLE.
        repeat (2) cycle(8'hFF, 1'b0, 1'b0);
        seen = 0;
        cycle(8'h7F, 1'b0, 1'b0);
        repeat (4) begin cycle(8'h7F, 1'b1, 1'b0); if (result_valid) seen = 1; end
        repeat (4) begin cycle(8'h7F, 1'b0, 1'b0); if (result_valid) seen = 1; end
        check_eq("abort_no_result", 32'(seen), 0);

        // Reset in the middle of timing, then a fresh 3 ms measurement.
        repeat (2) cycle(8'hFF, 1'b0, 1'b0);
        for (int i = 0; i < 21; i++) cycle(8'h00, 1'b0, 1'b0);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_eq("mid_rst_out", 32'({result_ms, result_valid, false_start, timeout, busy}), 0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        cycle(8'h00, 1'b0, 1'b0);
        repeat (2) cycle(8'hFF, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) cycle(8'h00, (i >= 14), 1'b0);
        check_eq("fresh_ms", 32'(result_ms), 3);
        cycle(8'h00, 1'b0, 1'b1);

        // Randomized transactions against the model.
        for (int n = 0; n < 60; n++) begin
            int pick, dly, hold;
            hold = $urandom_range(1, 4);
            for (int i = 0; i < hold; i++) cycle(8'hFF, 1'b0, 1'($urandom_range(0, 1)));
            pick = $urandom_range(0, 7);
            if (pick == 0) begin
                repeat (3) cycle(8'hFF, 1'b1, 1'($urandom_range(0, 1)));
            end else if (pick == 1) begin
                cycle(8'($urandom), 1'b0, 1'($urandom_range(0, 1)));
            end else begin
                dly = $urandom_range(0, 100);
                for (int i = 0; i < dly; i++) cycle(8'h00, 1'b0, 1'($urandom_range(0, 1)));
                repeat (3) cycle(8'h00, 1'b1, 1'($urandom_range(0, 1)));
            end
            for (int i = 0; i < 300 && ph != PH_IDLE; i++) cycle(8'h00, 1'b0, 1'($urandom_range(0, 1)));
            if (ph != PH_IDLE) check_eq("drain_bound", 32'(ph), PH_IDLE);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/f1_reaction_timer.md
# f1_reaction_timer

Downstream consumer of the F1 start-light sequencer's 8-bit light vector. Arms when all eight lights are lit and starts a millisecond count when they go out. Stops the count on the driver's trigger press and returns the reaction time over a valid/ready result interface. Also flags false starts (press before lights-out) and timeouts.

## Interface
- TICK_DIV, default 1000: clk cycles per millisecond tick; at least 2.
- CNT_WIDTH, default 16: width of the reaction-time counter, in ms.
- TIMEOUT_MS, default 9999: saturation limit in ms; must fit in CNT_WIDTH.
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- lights  in  8  light vector from the start-light sequencer, same clock domain.
- trigger  in  1  driver pushbutton, level, active-high.
- result_ready  in  1  consumer accepts the result.
- result_ms  out  CNT_WIDTH  reaction time in ms.
- result_valid  out  1  result_ms and flags are valid.
- false_start  out  1  qualifies the result: trigger pressed before lights-out.
- timeout  out  1  qualifies the result: no press within TIMEOUT_MS.
- busy  out  1  high in ARMED and TIMING.

## Operation
- Reset values: result_ms=0, result_valid=0, false_start=0, timeout=0, busy=0. State is IDLE, the tick prescaler is 0, and the trigger history is 0.
- trig_edge is the rising edge of the (optionally synchronised) trigger. It is derived from a registered copy of the trigger.
- **IDLE**
  - lights==8'hFF: go to ARMED.
  - All else ignored, including trigger.
- **ARMED**
  - lights==8'h00 and trig_edge in the same cycle: go to DONE with result_ms=0 and no flags.
  - trig_edge with lights!=8'h00: go to DONE with false_start=1 and result_ms=0.
  - lights==8'h00: go to TIMING. The ms counter and prescaler clear to 0.
  - Any other value besides 8'hFF: abort to IDLE with no result.
- **TIMING**
  - Prescaler counts 0..TICK_DIV-1. On wrap the ms counter increments.
  - trig_edge: go to DONE with result_ms = the counter value including any tick occurring in the same cycle.
  - Counter reaches TIMEOUT_MS: go to DONE with timeout=1 and result_ms=TIMEOUT_MS. Timeout wins over a same-cycle trig_edge.
- **DONE**
  - result_valid=1. result_ms and flags are held stable.
  - result_valid && result_ready: go to IDLE. result_valid and the flags clear next cycle; result_ms holds its last value.
  - Lights and trigger are ignored.
- The ms counter never wraps; it saturates at TIMEOUT_MS.

## Timing
- Lights-out to TIMING: 1 cycle.
- First ms increment: TICK_DIV cycles after entry to TIMING.
- Press to trig_edge: 1 cycle without synchroniser, 3 cycles with it.
- trig_edge to result_valid: 1 cycle (registered).
- result_valid stays high indefinitely until the handshake completes; backpressure is unbounded.
- Asserting rst in any state returns all outputs to their reset values immediately. Any in-flight measurement is discarded.

## Configuration
- F1_TRIGGER_SYNC_EN defined: a two-flop synchroniser precedes edge detection. Press-to-edge latency is 3 cycles.
- Without F1_TRIGGER_SYNC_EN: trigger is treated as synchronous to clk. Press-to-edge latency is 1 cycle.
- Reported result_ms values are defined relative to trig_edge, so they are identical between builds apart from this latency.

## Structure
- The shared package f1_pkg holds:
  - the state enum {IDLE, ARMED, TIMING, DONE};
  - the constants LIGHTS_ALL_ON=8'hFF and LIGHTS_ALL_OFF=8'h00.
- One sub-module, f1_ms_tick: a prescaler with a synchronous clear input, producing a one-cycle tick every TICK_DIV cycles.

## Test plan
Scenarios use TICK_DIV=4, TIMEOUT_MS=20, synchroniser off.
- Lights 00→FF→00, then trigger held high starting 4×7+2 cycles after lights-out → result_valid with result_ms=7, no flags.
- Lights FF, trigger pressed while lights are still FF → false_start=1, result_ms=0; busy falls one cycle after result_valid rises.
- Lights FF→00, no press → timeout=1, result_ms=20, result_valid after 80 cycles in TIMING.
- result_ready held low for 50 cycles while DONE → result_valid, result_ms and flags stable throughout; one ready pulse → result_valid low next cycle, state IDLE.
- Lights FF→0x7F while ARMED → back to IDLE with no result_valid; a trigger press in IDLE produces no result.
- rst asserted mid-TIMING at count 5 → all outputs 0 immediately; a fresh 00→FF→00 sequence then measures from 0.
